ay_ledsw_ctrl: RTL and testbench

AY_LEDSW_CTRL -- requirements
Module: ay_ledsw_ctrl

---
 rtl/ay_ledsw_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_ay_ledsw_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ay_ledsw_ctrl.sv
// AXI4-Lite LED/switch controller: debounced switch inputs with sticky edge
// interrupts, and LED outputs that are either static or blink at a programmable rate.
module ay_ledsw_ctrl #(
  parameter int unsigned N_LED           = 8,
  parameter int unsigned N_SW            = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 1000,
  parameter logic [31:0] BLINK_DEFAULT   = 32'd50000000
) (
  input  logic             ACLK,
  input  logic             ARESETN,
  input  logic [4:0]       S_AXI_AWADDR,
  input  logic             S_AXI_AWVALID,
  output logic             S_AXI_AWREADY,
  input  logic [31:0]      S_AXI_WDATA,
  input  logic [3:0]       S_AXI_WSTRB,
  input  logic             S_AXI_WVALID,
  output logic             S_AXI_WREADY,
  output logic [1:0]       S_AXI_BRESP,
  output logic             S_AXI_BVALID,
  input  logic             S_AXI_BREADY,
  input  logic [4:0]       S_AXI_ARADDR,
  input  logic             S_AXI_ARVALID,
  output logic             S_AXI_ARREADY,
  output logic [31:0]      S_AXI_RDATA,
  output logic [1:0]       S_AXI_RRESP,
  output logic             S_AXI_RVALID,
  input  logic             S_AXI_RREADY,
  input  logic [N_SW-1:0]  SW,
  output logic [N_LED-1:0] LED,
  output logic             IRQ
);
  localparam int unsigned      CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_TC   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [31:0]      ID_VALUE = 32'h4C53_0200;
  localparam logic [2:0] A_LED_OUT  = 3'd0;
  localparam logic [2:0] A_LED_MODE = 3'd1;
  localparam logic [2:0] A_SW_IN    = 3'd2;
  localparam logic [2:0] A_IRQ_STAT = 3'd3;
  localparam logic [2:0] A_IRQ_EN   = 3'd4;
  localparam logic [2:0] A_BLINK    = 3'd5;
  localparam logic [2:0] A_ID       = 3'd6;

  logic                       awready_q, bvalid_q, arready_q, rvalid_q;
  logic [31:0]                rdata_q, rd_mux;
  logic [N_LED-1:0]           led_out_q, led_out_d, led_mode_q, led_mode_d, led_q;
  logic [N_SW-1:0]            irq_stat_q, irq_stat_d, irq_en_q, irq_en_d, irq_clr;
  logic [N_SW-1:0]            sync1_q, sync2_q, stable_q, stable_d, sw_edge;
  logic [N_SW-1:0][CNT_W-1:0] db_cnt_q, db_cnt_d;
  logic [31:0]                period_q, period_d, blink_cnt_q, blink_cnt_d;
  logic                       phase_q, phase_d, irq_q;
  logic                       wr_en, rd_en, period_wr;
  logic [2:0]                 wr_sel;
  logic [31:0]                wmask;
  logic                       unused_addr_lsbs;

  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                        input logic [31:0] mask);
    return (old_v & ~mask) | (new_v & mask);
  endfunction

  assign unused_addr_lsbs = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // The ready pulse marks the accept cycle; the master holds its valids through it.
  assign wr_en     = awready_q & S_AXI_AWVALID & S_AXI_WVALID;
  assign rd_en     = arready_q & S_AXI_ARVALID;
  assign wr_sel    = S_AXI_AWADDR[4:2];
  assign wmask     = {{8{S_AXI_WSTRB[3]}}, {8{S_AXI_WSTRB[2]}}, {8{S_AXI_WSTRB[1]}}, {8{S_AXI_WSTRB[0]}}};
  assign period_wr = wr_en & (wr_sel == A_BLINK);

  always_comb begin
    led_out_d  = led_out_q;
    led_mode_d = led_mode_q;
    irq_en_d   = irq_en_q;
    period_d   = period_q;
    irq_clr    = '0;
    if (wr_en) begin
      case (wr_sel)
        A_LED_OUT:  led_out_d  = N_LED'(merge(32'(led_out_q), S_AXI_WDATA, wmask));
        A_LED_MODE: led_mode_d = N_LED'(merge(32'(led_mode_q), S_AXI_WDATA, wmask));
        A_IRQ_STAT: irq_clr    = N_SW'(S_AXI_WDATA & wmask);
        A_IRQ_EN:   irq_en_d   = N_SW'(merge(32'(irq_en_q), S_AXI_WDATA, wmask));
        A_BLINK:    period_d   = merge(period_q, S_AXI_WDATA, wmask);
        default:    ;
      endcase
    end
  end

  // Stable value only moves after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_comb begin
    stable_d = stable_q;
    sw_edge  = '0;
    for (int i = 0; i < int'(N_SW); i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (db_cnt_q[i] == CNT_TC) begin
          stable_d[i] = sync2_q[i];
          sw_edge[i]  = 1'b1;
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + CNT_W'(1);
        end
      end
    end
    // A new edge wins over a simultaneous clear of the same bit.
    irq_stat_d = (irq_stat_q & ~irq_clr) | sw_edge;
  end

  always_comb begin
    blink_cnt_d = blink_cnt_q + 32'd1;
    phase_d     = phase_q;
    if (period_wr || (period_q == '0)) begin
      blink_cnt_d = '0;
      phase_d     = 1'b0;
    end else if (blink_cnt_q == (period_q - 32'd1)) begin
      blink_cnt_d = '0;
      phase_d     = ~phase_q;
    end
  end

  always_comb begin
    rd_mux = '0;
    case (S_AXI_ARADDR[4:2])
      A_LED_OUT:  rd_mux = 32'(led_out_q);
      A_LED_MODE: rd_mux = 32'(led_mode_q);
      A_SW_IN:    rd_mux = 32'(stable_q);
      A_IRQ_STAT: rd_mux = 32'(irq_stat_q);
      A_IRQ_EN:   rd_mux = 32'(irq_en_q);
      A_BLINK:    rd_mux = period_q;
      A_ID:       rd_mux = ID_VALUE;
      default:    rd_mux = '0;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      awready_q   <= 1'b0;
      bvalid_q    <= 1'b0;
      arready_q   <= 1'b0;
      rvalid_q    <= 1'b0;
      rdata_q     <= '0;
      led_out_q   <= '0;
      led_mode_q  <= '0;
      irq_stat_q  <= '0;
      irq_en_q    <= '0;
      period_q    <= BLINK_DEFAULT;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
      sync1_q     <= '0;
      sync2_q     <= '0;
      stable_q    <= '0;
      db_cnt_q    <= '0;
      led_q       <= '0;
      irq_q       <= 1'b0;
    end else begin
      awready_q <= ~awready_q & S_AXI_AWVALID & S_AXI_WVALID & ~bvalid_q;
      if (wr_en)             bvalid_q <= 1'b1;
      else if (S_AXI_BREADY) bvalid_q <= 1'b0;
      arready_q <= ~arready_q & S_AXI_ARVALID & ~rvalid_q;
      if (rd_en) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_mux;
      end else if (S_AXI_RREADY) begin
        rvalid_q <= 1'b0;
      end
      led_out_q   <= led_out_d;
      led_mode_q  <= led_mode_d;
      irq_stat_q  <= irq_stat_d;
      irq_en_q    <= irq_en_d;
      period_q    <= period_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      sync1_q     <= SW;
      sync2_q     <= sync1_q;
      stable_q    <= stable_d;
      db_cnt_q    <= db_cnt_d;
      led_q       <= (led_out_q & ~led_mode_q) | (led_out_q & led_mode_q & {N_LED{phase_q}});
      irq_q       <= |(irq_stat_q & irq_en_q);
    end
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = awready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = 2'b00;
  assign LED           = led_q;
  assign IRQ           = irq_q;

endmodule

// File: tb/tb_ay_ledsw_ctrl.sv
// Bench for ay_ledsw_ctrl: directed register/debounce/blink/back-pressure/reset
// scenarios plus random traffic, all compared against a behavioural model.
module tb_ay_ledsw_ctrl;
  localparam int DC = 4;

  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b0;
  logic [4:0]  aw_addr = '0;
  logic        aw_valid = 1'b0;
  logic [31:0] w_data = '0;
  logic [3:0]  w_strb = '0;
  logic        w_valid = 1'b0;
  logic        b_ready = 1'b0;
  logic [4:0]  ar_addr = '0;
  logic        ar_valid = 1'b0;
  logic        r_ready = 1'b0;
  logic [3:0]  sw = '0;
  logic        awready, wready, bvalid, arready, rvalid, irq;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;
  logic [7:0]  led;

  logic [3:0]  sw_cmd = '0;
  logic        sw_rand = 1'b0;
  int          sw_k;
  logic        cmp_en = 1'b0;
  int          checks = 0;
  int          failures = 0;

  // Behavioural model state
  logic [7:0]  m_ledout, m_mode, m_led;
  logic [3:0]  m_stat, m_en, m_stable, s1, s2, flip, clr;
  logic [31:0] m_period, m_rdata;
  logic        m_irq;
  int          run [4];
  longint      cyc, t0;

  ay_ledsw_ctrl #(.N_LED(8), .N_SW(4), .DEBOUNCE_CYCLES(DC), .BLINK_DEFAULT(32'd3)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .S_AXI_AWADDR(aw_addr), .S_AXI_AWVALID(aw_valid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(w_data), .S_AXI_WSTRB(w_strb), .S_AXI_WVALID(w_valid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(b_ready),
    .S_AXI_ARADDR(ar_addr), .S_AXI_ARVALID(ar_valid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(r_ready),
    .SW(sw), .LED(led), .IRQ(irq)
  );

  always #5 ACLK = ~ACLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Blink phase after `cyc` edges: whole half-periods elapsed since the last clear.
  function automatic logic m_phase();
    if (m_period == '0) return 1'b0;
    return (((cyc - t0) / longint'(m_period)) % 2) == 1;
  endfunction

  function automatic logic [31:0] m_reg(input logic [4:0] a);
    case (a[4:2])
      3'd0:    return {24'b0, m_ledout};
      3'd1:    return {24'b0, m_mode};
      3'd2:    return {28'b0, m_stable};
      3'd3:    return {28'b0, m_stat};
      3'd4:    return {28'b0, m_en};
      3'd5:    return m_period;
      3'd6:    return 32'h4C53_0200;
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      m_ledout = '0; m_mode = '0; m_stat = '0; m_en = '0; m_period = 32'd3;
      m_stable = '0; s1 = '0; s2 = '0; flip = '0; clr = '0;
      for (int i = 0; i < 4; i++) run[i] = 0;
      cyc = 0; t0 = 0; m_led = '0; m_irq = 1'b0; m_rdata = '0;
    end else begin
      m_led = m_ledout & (~m_mode | {8{m_phase()}});
      m_irq = |(m_stat & m_en);
      if (arready && ar_valid) m_rdata = m_reg(ar_addr);
      flip = '0;
      for (int i = 0; i < 4; i++) begin
        if (s2[i] != m_stable[i]) begin
          run[i]++;
          if (run[i] == DC) begin
            flip[i] = 1'b1;
            run[i]  = 0;
          end
        end else begin
          run[i] = 0;
        end
      end
      m_stable = m_stable ^ flip;
      s2 = s1;
      s1 = sw;
      cyc++;
      clr = '0;
      if (awready && aw_valid && w_valid) begin
        case (aw_addr[4:2])
          3'd0: if (w_strb[0]) m_ledout = w_data[7:0];
          3'd1: if (w_strb[0]) m_mode = w_data[7:0];
          3'd3: if (w_strb[0]) clr = w_data[3:0];
          3'd4: if (w_strb[0]) m_en = w_data[3:0];
          3'd5: begin
            for (int b = 0; b < 4; b++) if (w_strb[b]) m_period[8*b +: 8] = w_data[8*b +: 8];
            t0 = cyc;
          end
          default: ;
        endcase
      end
      m_stat = (m_stat & ~clr) | flip;
    end
  end

  always @(negedge ACLK) begin
    if (ARESETN && cmp_en) begin
      chk("led_model", 32'(led), 32'(m_led));
      chk("irq_model", 32'(irq), 32'(m_irq));
    end
  end

  always @(negedge ACLK) begin
    if (sw_rand) begin
      if ($urandom_range(0, 2) == 0) begin
        sw_k = int'($urandom_range(0, 3));
        sw[sw_k] = ~sw[sw_k];
      end
    end else begin
      sw = sw_cmd;
    end
  end

  task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                           input bit hold);
    int n;
    aw_addr = a; w_data = d; w_strb = s; aw_valid = 1'b1; w_valid = 1'b1; b_ready = !hold;
    n = 0;
    do begin @(negedge ACLK); n++; end while (!awready && n < 32);
    chk("aw_accept", 32'(awready), 32'd1);
    chk("w_ready_with_aw", 32'(wready), 32'(awready));
    @(negedge ACLK);
    chk("bvalid_after_accept", 32'(bvalid), 32'd1);
    chk("aw_ready_pulse", 32'(awready), 32'd0);
    chk("bresp", 32'(bresp), 32'd0);
    if (hold) begin
      aw_addr = 5'h00; w_data = 32'h22; w_strb = 4'hF;
      repeat (5) begin
        @(negedge ACLK);
        chk("bvalid_held", 32'(bvalid), 32'd1);
        chk("second_aw_blocked", 32'(awready), 32'd0);
      end
    end
    aw_valid = 1'b0; w_valid = 1'b0; b_ready = 1'b1;
    @(negedge ACLK);
    chk("bvalid_cleared", 32'(bvalid), 32'd0);
    b_ready = 1'b0;
  endtask

  task automatic axi_read(input logic [4:0] a, input int hold, output logic [31:0] d);
    int n;
    ar_addr = a; ar_valid = 1'b1; r_ready = (hold == 0);
    n = 0;
    do begin @(negedge ACLK); n++; end while (!arready && n < 32);
    chk("ar_accept", 32'(arready), 32'd1);
    @(negedge ACLK);
    ar_valid = 1'b0;
    chk("rvalid_after_accept", 32'(rvalid), 32'd1);
    chk("rdata_model", rdata, m_rdata);
    chk("rresp", 32'(rresp), 32'd0);
    d = rdata;
    repeat (hold) begin
      @(negedge ACLK);
      chk("rvalid_held", 32'(rvalid), 32'd1);
      chk("rdata_stable", rdata, m_rdata);
    end
    r_ready = 1'b1;
    @(negedge ACLK);
    chk("rvalid_cleared", 32'(rvalid), 32'd0);
    r_ready = 1'b0;
  endtask

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] d, d2;
    logic [11:0] blink_pat;
    logic [4:0]  ra;
    logic [31:0] rd;
    blink_pat = 12'b111_000_111_000;

    repeat (3) @(negedge ACLK);
    #2 ARESETN = 1'b1;
    @(negedge ACLK);
    cmp_en = 1'b1;

    chk("reset_led", 32'(led), 32'h0);
    chk("reset_irq", 32'(irq), 32'h0);
    chk("reset_bvalid", 32'(bvalid), 32'h0);
    axi_read(5'h18, 0, d); chk("id_reg", d, 32'h4C53_0200);
    axi_read(5'h00, 0, d); chk("led_out_reset", d, 32'h0);
    axi_read(5'h14, 0, d); chk("blink_reset", d, 32'd3);

    axi_write(5'h00, 32'hFFFF_FFA5, 4'b0001, 0);
    chk("led_a5", 32'(led), 32'hA5);
    axi_read(5'h00, 0, d); chk("led_out_rb", d, 32'hA5);
    axi_write(5'h00, 32'h0000_0012, 4'b0000, 0);
    axi_read(5'h00, 0, d); chk("strb0_no_change", d, 32'hA5);
    axi_write(5'h1C, 32'hFFFF_FFFF, 4'hF, 0);
    axi_read(5'h1C, 0, d); chk("unmapped_rd0", d, 32'h0);

    sw_cmd = 4'b0001;
    repeat (3) @(negedge ACLK);
    sw_cmd = 4'b0000;
    repeat (10) @(negedge ACLK);
    axi_read(5'h08, 0, d); chk("sw_glitch_in", d, 32'h0);
    axi_read(5'h0C, 0, d); chk("sw_glitch_stat", d, 32'h0);
    sw_cmd = 4'b0001;
    repeat (10) @(negedge ACLK);
    axi_read(5'h08, 0, d); chk("sw_held_in", d, 32'h1);
    axi_read(5'h0C, 0, d); chk("sw_held_stat", d, 32'h1);
    axi_write(5'h10, 32'h1, 4'hF, 0);
    chk("irq_enabled", 32'(irq), 32'h1);
    axi_write(5'h0C, 32'h1, 4'hF, 0);
    chk("irq_after_w1c", 32'(irq), 32'h0);
    axi_read(5'h0C, 0, d); chk("stat_after_w1c", d, 32'h0);

    axi_write(5'h00, 32'h03, 4'hF, 0);
    axi_write(5'h04, 32'h01, 4'hF, 0);
    axi_write(5'h14, 32'd3, 4'hF, 0);
    for (int j = 0; j < 12; j++) begin
      chk("blink_seq", 32'(led), {30'b0, 1'b1, blink_pat[j]});
      @(negedge ACLK);
    end
    axi_write(5'h14, 32'd0, 4'hF, 0);
    repeat (4) begin
      chk("blink_off", 32'(led), 32'h02);
      @(negedge ACLK);
    end

    axi_write(5'h00, 32'h11, 4'hF, 1);
    axi_read(5'h00, 0, d); chk("second_write_dropped", d, 32'h11);
    axi_read(5'h14, 5, d); chk("held_read", d, 32'h0);

    fork
      axi_write(5'h10, 32'hF, 4'b0001, 0);
      axi_read(5'h00, 0, d2);
    join
    chk("concurrent_rd", d2, 32'h11);

    sw_rand = 1'b1;
    for (int it = 0; it < 150; it++) begin
      ra = 5'($urandom_range(0, 7) << 2);
      rd = $urandom;
      if (ra[4:2] == 3'd5) rd = $urandom_range(0, 6);
      case ($urandom_range(0, 3))
        0: axi_write(ra, rd, 4'($urandom_range(0, 15)), 0);
        1: axi_read(ra, int'($urandom_range(0, 2)), d);
        2: repeat ($urandom_range(1, 10)) @(negedge ACLK);
        default: begin
          fork
            axi_write(ra, rd, 4'hF, 0);
            axi_read(5'($urandom_range(0, 7) << 2), 0, d2);
          join
        end
      endcase
    end
    sw_rand = 1'b0;
    sw_cmd  = 4'b0000;

    axi_write(5'h04, 32'h0, 4'hF, 0);
    axi_write(5'h00, 32'hA5, 4'b0001, 0);
    chk("pre_reset_led", 32'(led), 32'hA5);
    aw_addr = 5'h10; w_data = 32'h0; w_strb = 4'hF; aw_valid = 1'b1; w_valid = 1'b1; b_ready = 1'b0;
    begin
      int n;
      n = 0;
      do begin @(negedge ACLK); n++; end while (!awready && n < 32);
      chk("rst_aw_accept", 32'(awready), 32'd1);
    end
    @(negedge ACLK);
    aw_valid = 1'b0; w_valid = 1'b0;
    chk("rst_bvalid_pending", 32'(bvalid), 32'd1);
    #2 ARESETN = 1'b0;
    #1;
    chk("async_rst_bvalid", 32'(bvalid), 32'd0);
    chk("async_rst_led", 32'(led), 32'd0);
    chk("async_rst_irq", 32'(irq), 32'd0);
    repeat (2) @(negedge ACLK);
    #2 ARESETN = 1'b1;
    @(negedge ACLK);
    axi_write(5'h00, 32'h3C, 4'hF, 0);
    chk("post_reset_led", 32'(led), 32'h3C);
    axi_read(5'h00, 0, d); chk("post_reset_rb", d, 32'h3C);
    axi_read(5'h14, 0, d); chk("post_reset_blink", d, 32'd3);
    axi_read(5'h0C, 0, d); chk("post_reset_stat", d, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
